// File: rtl/sort_pkg.sv
// Shared types and helpers for the odd-even transposition stream sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic ORDER_ASC  = 1'b0;
  localparam logic ORDER_DESC = 1'b1;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Unsigned compare-exchange: lo lands at the lower index, hi at the upper.
module cmp_swap
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swapped
);

  // Strict compares so equal values never swap.
  assign swapped = (desc == ORDER_DESC) ? (a < b) : (a > b);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/stream_sorter.sv
// Serial-in, serial-out batch sorter: load DEPTH words, odd-even transposition sort
// one phase per clock, then stream the words out in the requested order.
module stream_sorter
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_desc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned IW     = idx_width(DEPTH);
  localparam int unsigned NPAIR  = DEPTH / 2;
  localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, phase_q, phase_d;
  logic [1:0]      noswap_q, noswap_d;
  logic            mode_q, mode_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] sorted [DEPTH];

  logic [WIDTH-1:0] pa [NPAIR];
  logic [WIDTH-1:0] pb [NPAIR];
  logic [WIDTH-1:0] plo [NPAIR];
  logic [WIDTH-1:0] phi [NPAIR];
  logic [NPAIR-1:0] pswp, pen;
  logic             ph_odd, swapped;

  assign ph_odd = phase_q[0];

  // Pair k covers (2k,2k+1) on even phases and (2k+1,2k+2) on odd phases when it exists.
  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    if (2 * k + 2 < DEPTH) begin : g_both
      assign pa[k]  = ph_odd ? mem_q[2*k+1] : mem_q[2*k];
      assign pb[k]  = ph_odd ? mem_q[2*k+2] : mem_q[2*k+1];
      assign pen[k] = 1'b1;
    end else begin : g_even_only
      assign pa[k]  = mem_q[2*k];
      assign pb[k]  = mem_q[2*k+1];
      assign pen[k] = ~ph_odd;
    end
    cmp_swap #(.WIDTH(WIDTH)) u_cmp (
      .a      (pa[k]),
      .b      (pb[k]),
      .desc   (mode_q),
      .lo     (plo[k]),
      .hi     (phi[k]),
      .swapped(pswp[k])
    );
  end

  assign swapped = |(pswp & pen);

  for (genvar j = 0; j < DEPTH; j++) begin : g_elem
    logic [WIDTH-1:0] ev, od;
    if (j / 2 < NPAIR) begin : g_ev
      assign ev = (j % 2 == 0) ? plo[j/2] : phi[j/2];
    end else begin : g_ev_keep
      assign ev = mem_q[j];
    end
    if ((j >= 1) && ((j % 2 == 0) || (j + 1 < DEPTH))) begin : g_od
      assign od = (j % 2 == 1) ? plo[(j-1)/2] : phi[(j-1)/2];
    end else begin : g_od_keep
      assign od = mem_q[j];
    end
    assign sorted[j] = ph_odd ? od : ev;
  end

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    phase_d    = phase_q;
    noswap_d   = noswap_q;
    mode_d     = mode_q;
    mem_d      = mem_q;
    out_data_d = '0;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_d[wr_idx_q] = in_data;
          if (wr_idx_q == '0) mode_d = in_desc;
          if (wr_idx_q == LastIdx) begin
            state_d  = SORT;
            wr_idx_d = '0;
            phase_d  = '0;
            noswap_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      SORT: begin
        mem_d    = sorted;
        noswap_d = swapped ? 2'd0 : noswap_q + 2'd1;
        phase_d  = phase_q + 1'b1;
        rd_idx_d = '0;
        if ((noswap_d == 2'd2) || (phase_q == LastIdx)) begin
          state_d    = DRAIN;
          out_data_d = sorted[0];
        end
      end
      DRAIN: begin
        out_data_d = out_data_q;
        if (out_ready) begin
          if (rd_idx_q == LastIdx) begin
            state_d    = LOAD;
            rd_idx_d   = '0;
            wr_idx_d   = '0;
            out_data_d = '0;
          end else begin
            rd_idx_d   = rd_idx_q + 1'b1;
            out_data_d = mem_q[rd_idx_d];
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      phase_q    <= '0;
      noswap_q   <= '0;
      mode_q     <= ORDER_ASC;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      phase_q    <= phase_d;
      noswap_q   <= noswap_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset; contents are rewritten by every batch.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && (rd_idx_q == LastIdx);
  assign out_data  = out_data_q;
  assign busy      = (state_q != LOAD);

endmodule
